multi_cycle_cpu: RTL and testbench

//  Parametrised RV32I successor to the single-cycle core: multi-cycle FSM over one unified

---
 rtl/multi_cycle_cpu.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_multi_cycle_cpu.sv | 491 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_cpu.sv
// Multi-cycle RV32I core with a single unified memory port (req/ready handshake).
// Sequence: BOOT -> FETCH -> DECODE -> EXEC -> [MEM -> [WB]] -> FETCH, with
// byte-lane store strobes, offset-aligned load extension and trap detection.
module multi_cycle_cpu #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0010,
    parameter bit          HALT_ON_TRAP = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        retire,
    output logic        halted,
    output logic [1:0]  trap_cause
);
    localparam logic [2:0] S_BOOT   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [2:0]  state;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] rs1_q;
    logic [31:0] rs2_q;
    logic [31:0] imm_q;
    logic [31:0] ls_addr_q;
    logic [1:0]  ls_off_q;
    logic [31:0] st_data_q;
    logic [3:0]  st_strb_q;
    logic [31:0] ld_data_q;
    logic [31:0] regs [0:31];

    logic [6:0]  opcode;
    logic [4:0]  rd_idx;
    logic [2:0]  funct3;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [31:0] rs1_rd;
    logic [31:0] rs2_rd;
    logic [31:0] imm_dec;

    logic        is_load;
    logic        is_store;
    logic        is_system;
    logic        legal;
    logic [31:0] alu_b;
    logic [31:0] alu_res;
    logic        br_cond;
    logic        taken;
    logic [31:0] target;
    logic [31:0] next_pc;
    logic        writes_rd;
    logic [31:0] wb_val;
    logic [31:0] ls_addr;
    logic        ls_misal;
    logic        exec_trap;
    logic [1:0]  exec_cause;
    logic [3:0]  st_strb;
    logic [31:0] st_data;
    logic [31:0] ld_shift;
    logic [31:0] ld_ext;
    logic        rf_we;
    logic [31:0] rf_wd;

    assign opcode  = ir[6:0];
    assign rd_idx  = ir[11:7];
    assign funct3  = ir[14:12];
    assign rs1_idx = ir[19:15];
    assign rs2_idx = ir[24:20];
    assign rs1_rd  = (rs1_idx == 5'd0) ? '0 : regs[rs1_idx];
    assign rs2_rd  = (rs2_idx == 5'd0) ? '0 : regs[rs2_idx];

    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_system = (opcode == OP_SYSTEM);

    // Immediate formats selected by opcode
    always_comb begin
        imm_dec = {{20{ir[31]}}, ir[31:20]};
        case (opcode)
            OP_LUI, OP_AUIPC: imm_dec = {ir[31:12], 12'b0};
            OP_JAL:           imm_dec = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            OP_BRANCH:        imm_dec = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            OP_STORE:         imm_dec = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            default:          imm_dec = {{20{ir[31]}}, ir[31:20]};
        endcase
    end

    // ALU, branch resolution, next pc and writeback value for EXEC
    always_comb begin
        alu_b   = (opcode == OP_REG) ? rs2_q : imm_q;
        alu_res = '0;
        case (funct3)
            3'b000:  alu_res = (opcode == OP_REG && ir[30]) ? rs1_q - alu_b : rs1_q + alu_b;
            3'b001:  alu_res = rs1_q << alu_b[4:0];
            3'b010:  alu_res = {31'b0, $signed(rs1_q) < $signed(alu_b)};
            3'b011:  alu_res = {31'b0, rs1_q < alu_b};
            3'b100:  alu_res = rs1_q ^ alu_b;
            3'b101:  alu_res = ir[30] ? 32'($signed(rs1_q) >>> alu_b[4:0]) : rs1_q >> alu_b[4:0];
            3'b110:  alu_res = rs1_q | alu_b;
            default: alu_res = rs1_q & alu_b;
        endcase

        br_cond = 1'b0;
        case (funct3)
            3'b000:  br_cond = (rs1_q == rs2_q);
            3'b001:  br_cond = (rs1_q != rs2_q);
            3'b100:  br_cond = ($signed(rs1_q) < $signed(rs2_q));
            3'b101:  br_cond = ($signed(rs1_q) >= $signed(rs2_q));
            3'b110:  br_cond = (rs1_q < rs2_q);
            3'b111:  br_cond = (rs1_q >= rs2_q);
            default: br_cond = 1'b0;
        endcase

        taken   = (opcode == OP_JAL) || (opcode == OP_JALR) || ((opcode == OP_BRANCH) && br_cond);
        target  = (opcode == OP_JALR) ? ((rs1_q + imm_q) & ~32'd1) : (pc + imm_q);
        next_pc = taken ? target : pc + 32'd4;

        writes_rd = 1'b0;
        wb_val    = alu_res;
        case (opcode)
            OP_LUI:          begin writes_rd = 1'b1; wb_val = imm_q; end
            OP_AUIPC:        begin writes_rd = 1'b1; wb_val = pc + imm_q; end
            OP_JAL, OP_JALR: begin writes_rd = 1'b1; wb_val = pc + 32'd4; end
            OP_IMM, OP_REG:  begin writes_rd = 1'b1; wb_val = alu_res; end
            default:         begin writes_rd = 1'b0; wb_val = alu_res; end
        endcase
    end

    // Load/store address, lane steering and trap classification
    always_comb begin
        ls_addr  = rs1_q + imm_q;
        ls_misal = (funct3[1:0] == 2'b01 && ls_addr[0]) ||
                   (funct3[1] && ls_addr[1:0] != 2'b00);
        st_strb  = 4'b1111;
        st_data  = rs2_q;
        case (funct3[1:0])
            2'b00:   begin st_strb = 4'b0001 << ls_addr[1:0]; st_data = {4{rs2_q[7:0]}}; end
            2'b01:   begin st_strb = 4'b0011 << ls_addr[1:0]; st_data = {2{rs2_q[15:0]}}; end
            default: begin st_strb = 4'b1111; st_data = rs2_q; end
        endcase

        legal = (opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL) ||
                (opcode == OP_JALR) || (opcode == OP_BRANCH) || is_load || is_store ||
                (opcode == OP_IMM) || (opcode == OP_REG) || is_system;
        exec_cause = 2'd0;
        if (!legal)
            exec_cause = 2'd1;
        else if ((is_load || is_store) && ls_misal)
            exec_cause = 2'd2;
        else if (taken && target[1])
            exec_cause = 2'd3;
        exec_trap = (exec_cause != 2'd0);
    end

    // Load data alignment and sign/zero extension for WB
    always_comb begin
        ld_shift = ld_data_q >> {ls_off_q, 3'b000};
        case (funct3)
            3'b000:  ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_ext = {24'b0, ld_shift[7:0]};
            3'b101:  ld_ext = {16'b0, ld_shift[15:0]};
            default: ld_ext = ld_shift;
        endcase
    end

    // Retire strobe and register-file write port
    always_comb begin
        retire = ((state == S_EXEC) && !exec_trap && !is_load && !is_store) ||
                 ((state == S_MEM) && is_store && mem_ready) ||
                 (state == S_WB);
        rf_we  = 1'b0;
        rf_wd  = wb_val;
        if (state == S_EXEC && !exec_trap && writes_rd)
            rf_we = (rd_idx != 5'd0);
        else if (state == S_WB) begin
            rf_we = (rd_idx != 5'd0);
            rf_wd = ld_ext;
        end
    end

    // Memory port is driven only in FETCH and MEM so reset drops it at once
    always_comb begin
        mem_req   = (state == S_FETCH) || (state == S_MEM);
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (state == S_FETCH)
            mem_addr = pc;
        else if (state == S_MEM) begin
            mem_addr  = ls_addr_q;
            mem_wdata = st_data_q;
            mem_wstrb = st_strb_q;
        end
        halted = (state == S_HALT);
    end

    // Register file: x0 is never written and reads as zero
    always_ff @(posedge clk) begin
        if (rf_we)
            regs[rd_idx] <= rf_wd;
    end

    // Main control FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_BOOT;
            pc         <= RESET_VECTOR;
            ir         <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            imm_q      <= '0;
            ls_addr_q  <= '0;
            ls_off_q   <= '0;
            st_data_q  <= '0;
            st_strb_q  <= '0;
            ld_data_q  <= '0;
            trap_cause <= '0;
        end else begin
            case (state)
                S_BOOT: state <= S_FETCH;
                S_FETCH: begin
                    if (mem_ready) begin
                        ir    <= mem_rdata;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    rs1_q <= rs1_rd;
                    rs2_q <= rs2_rd;
                    imm_q <= imm_dec;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (exec_trap) begin
                        trap_cause <= exec_cause;
                        if (HALT_ON_TRAP)
                            state <= S_HALT;
                        else begin
                            pc    <= TRAP_VECTOR;
                            state <= S_FETCH;
                        end
                    end else if (is_system) begin
                        trap_cause <= '0;
                        state      <= S_HALT;
                    end else if (is_load || is_store) begin
                        ls_addr_q <= {ls_addr[31:2], 2'b00};
                        ls_off_q  <= ls_addr[1:0];
                        st_data_q <= st_data;
                        st_strb_q <= is_store ? st_strb : 4'b0000;
                        state     <= S_MEM;
                    end else begin
                        pc         <= next_pc;
                        trap_cause <= '0;
                        state      <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (is_store) begin
                            pc         <= pc + 32'd4;
                            trap_cause <= '0;
                            state      <= S_FETCH;
                        end else begin
                            ld_data_q <= mem_rdata;
                            state     <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    pc         <= pc + 32'd4;
                    trap_cause <= '0;
                    state      <= S_FETCH;
                end
                S_HALT: state <= S_HALT;
                default: state <= S_HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_multi_cycle_cpu.sv
// Bench for multi_cycle_cpu: word memory with programmable wait states, a store
// scoreboard (expected stores queued per program, observed stores captured from
// the bus) and per-scenario timing/trap checks. A second instance runs the same
// program with HALT_ON_TRAP=0 and zero wait states.
module tb_multi_cycle_cpu;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } st_t;

    logic        clk;
    logic        rst_n;
    logic        mem_req, mem_ready, retire, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic [1:0]  trap_cause;
    logic        req2, ready2, retire2, halted2;
    logic [31:0] addr2, wdata2, rdata2;
    logic [3:0]  wstrb2;
    logic [1:0]  cause2;

    logic [31:0] mem [0:127];
    int unsigned wait_cfg;
    int unsigned wait_cnt;
    int unsigned retire_cnt, retire2_cnt, data_req_cnt;
    st_t         obs_q[$];
    st_t         obs2_q[$];
    st_t         exp_q[$];
    st_t         exp2_q[$];
    int          total;
    int          bad;

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    multi_cycle_cpu u_dut (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .retire(retire), .halted(halted), .trap_cause(trap_cause)
    );

    multi_cycle_cpu #(.HALT_ON_TRAP(1'b0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .mem_req(req2), .mem_addr(addr2),
        .mem_wdata(wdata2), .mem_wstrb(wstrb2), .mem_ready(ready2),
        .mem_rdata(rdata2), .retire(retire2), .halted(halted2), .trap_cause(cause2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_ready = mem_req && (wait_cnt == wait_cfg);
    assign mem_rdata = mem[mem_addr[8:2]];
    assign ready2    = 1'b1;
    assign rdata2    = mem[addr2[8:2]];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_cnt <= 0;
        else if (mem_req && !mem_ready)
            wait_cnt <= wait_cnt + 1;
        else
            wait_cnt <= 0;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            obs_q.delete();
            obs2_q.delete();
            retire_cnt   <= 0;
            retire2_cnt  <= 0;
            data_req_cnt <= 0;
        end else begin
            if (mem_req && mem_ready && mem_wstrb != 4'b0000)
                obs_q.push_back('{addr: mem_addr, data: mem_wdata, strb: mem_wstrb});
            if (req2 && wstrb2 != 4'b0000)
                obs2_q.push_back('{addr: addr2, data: wdata2, strb: wstrb2});
            if (retire)  retire_cnt  <= retire_cnt + 1;
            if (retire2) retire2_cnt <= retire2_cnt + 1;
            if (mem_req && mem_addr >= 32'h100) data_req_cnt <= data_req_cnt + 1;
        end
    end

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic hold_reset();
        rst_n = 1'b0;
        exp_q.delete();
        exp2_q.delete();
        for (int i = 0; i < 128; i++) mem[i] = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic release_reset(input int unsigned waits);
        wait_cfg = waits;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_halt(input int unsigned budget, output bit ok);
        ok = 1'b0;
        for (int unsigned i = 0; i < budget; i++) begin
            @(negedge clk);
            if (halted) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        bit ok;
        hold_reset();
        mem[0] = EBREAK;
        wait_cfg = 3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({mem_req, mem_addr, mem_wdata, mem_wstrb, retire, halted, trap_cause} !== '0) begin
                bad++;
                $display("FAIL reset_outputs: got req=%b addr=%h wstrb=%b ret=%b halt=%b cause=%0d, want all 0",
                         mem_req, mem_addr, mem_wstrb, retire, halted, trap_cause);
            end
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (mem_req !== 1'b0) begin
            bad++;
            $display("FAIL boot_no_req: mem_req=%b want 0", mem_req);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h0 || mem_wstrb !== 4'b0000) begin
                bad++;
                $display("FAIL first_fetch: req=%b addr=%h wstrb=%b want 1/00000000/0000",
                         mem_req, mem_addr, mem_wstrb);
            end
        end
        wait_halt(100, ok);
        total++;
        if (!ok || trap_cause !== 2'd0) begin
            bad++;
            $display("FAIL reset_prog_halt: halted=%b cause=%0d want 1/0", halted, trap_cause);
        end
    endtask

    task automatic test_alu();
        int unsigned cyc, nret, r1, r2;
        bit checked;
        st_t e;
        hold_reset();
        mem[0] = enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011);
        mem[1] = {7'b0, 5'd1, 5'd1, 3'b000, 5'd2, 7'b0110011};
        mem[2] = enc_s(12'h100, 5'd2, 5'd0, 3'b010);
        mem[3] = EBREAK;
        exp_q.push_back('{addr: 32'h100, data: 32'd10, strb: 4'b1111});
        release_reset(0);
        cyc = 0; nret = 0; r1 = 0; r2 = 0; checked = 1'b0;
        while (!halted && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (nret == 2 && !checked) begin
                checked = 1'b1;
                total++;
                if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin
                    bad++;
                    $display("FAIL alu_pc8: req=%b addr=%h want 1/00000008", mem_req, mem_addr);
                end
            end
            if (retire === 1'b1) begin
                nret++;
                if (nret == 1) r1 = cyc;
                if (nret == 2) r2 = cyc;
            end
        end
        repeat (2) @(negedge clk);
        total++;
        if (r1 != 3 || r2 != 6) begin
            bad++;
            $display("FAIL alu_retire_timing: retires at %0d,%0d want 3,6", r1, r2);
        end
        total++;
        if (!halted || retire_cnt != 4) begin
            bad++;
            $display("FAIL alu_retire_count: halted=%b retires=%0d want 1/4", halted, retire_cnt);
        end
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL alu_store_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q[i] !== e) begin
                bad++;
                $display("FAIL alu_store%0d: got %h want %h", i, obs_q[i], e);
            end
        end
    endtask

    task automatic test_store_load();
        bit ok;
        st_t e;
        hold_reset();
        mem[0]  = enc_i(12'd10, 5'd0, 3'b000, 5'd2, 7'b0010011);
        mem[1]  = enc_i(12'h103, 5'd0, 3'b000, 5'd3, 7'b0010011);
        mem[2]  = enc_s(12'd0, 5'd2, 5'd3, 3'b000);
        mem[3]  = enc_s(12'hFFF, 5'd3, 5'd3, 3'b001);
        mem[4]  = enc_i(12'd0, 5'd3, 3'b000, 5'd4, 7'b0000011);
        mem[5]  = enc_i(12'd0, 5'd3, 3'b100, 5'd5, 7'b0000011);
        mem[6]  = enc_i(12'hFFF, 5'd3, 3'b001, 5'd6, 7'b0000011);
        mem[7]  = enc_s(12'h110, 5'd4, 5'd0, 3'b010);
        mem[8]  = enc_s(12'h114, 5'd5, 5'd0, 3'b010);
        mem[9]  = enc_s(12'h118, 5'd6, 5'd0, 3'b010);
        mem[10] = EBREAK;
        mem[64] = 32'h8000_0000;
        exp_q.push_back('{addr: 32'h100, data: 32'h0A0A_0A0A, strb: 4'b1000});
        exp_q.push_back('{addr: 32'h100, data: 32'h0103_0103, strb: 4'b1100});
        exp_q.push_back('{addr: 32'h110, data: 32'hFFFF_FF80, strb: 4'b1111});
        exp_q.push_back('{addr: 32'h114, data: 32'h0000_0080, strb: 4'b1111});
        exp_q.push_back('{addr: 32'h118, data: 32'hFFFF_8000, strb: 4'b1111});
        release_reset(0);
        wait_halt(200, ok);
        total++;
        if (!ok || retire_cnt != 11) begin
            bad++;
            $display("FAIL ls_halt: halted=%b retires=%0d want 1/11", halted, retire_cnt);
        end
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL ls_store_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q[i] !== e) begin
                bad++;
                $display("FAIL ls_store%0d: got %h want %h", i, obs_q[i], e);
            end
        end
    endtask

    task automatic test_wait_states();
        int unsigned cyc, first_ret;
        logic        prev_req, prev_rdy;
        logic [67:0] prev_bus;
        bit          stable;
        st_t         e;
        hold_reset();
        mem[0]  = enc_i(12'h103, 5'd0, 3'b100, 5'd5, 7'b0000011);
        mem[1]  = enc_s(12'h110, 5'd5, 5'd0, 3'b010);
        mem[2]  = EBREAK;
        mem[64] = 32'h8000_0000;
        exp_q.push_back('{addr: 32'h110, data: 32'h0000_0080, strb: 4'b1111});
        release_reset(4);
        cyc = 0; first_ret = 0; stable = 1'b1; prev_req = 1'b0; prev_rdy = 1'b0; prev_bus = '0;
        while (!halted && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (mem_req && prev_req && !prev_rdy && {mem_addr, mem_wdata, mem_wstrb} !== prev_bus)
                stable = 1'b0;
            prev_req = mem_req;
            prev_rdy = mem_ready;
            prev_bus = {mem_addr, mem_wdata, mem_wstrb};
            if (retire === 1'b1 && first_ret == 0) first_ret = cyc;
        end
        repeat (2) @(negedge clk);
        total++;
        if (first_ret != 13) begin
            bad++;
            $display("FAIL wait_load_latency: first retire at cycle %0d want 13", first_ret);
        end
        total++;
        if (!stable) begin
            bad++;
            $display("FAIL wait_bus_stable: stable=%b want 1", stable);
        end
        total++;
        if (!halted || retire_cnt != 3) begin
            bad++;
            $display("FAIL wait_retires: halted=%b retires=%0d want 1/3", halted, retire_cnt);
        end
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL wait_store_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q[i] !== e) begin
                bad++;
                $display("FAIL wait_store%0d: got %h want %h", i, obs_q[i], e);
            end
        end
    endtask

    task automatic test_branch_jump();
        bit ok;
        st_t e;
        hold_reset();
        mem[0]  = enc_i(12'd0, 5'd0, 3'b000, 5'd7, 7'b0010011);
        mem[1]  = enc_b(13'd8, 5'd0, 5'd0, 3'b000);
        mem[2]  = enc_i(12'd1, 5'd0, 3'b000, 5'd7, 7'b0010011);
        mem[3]  = enc_b(13'd8, 5'd0, 5'd0, 3'b001);
        mem[4]  = enc_i(12'h021, 5'd0, 3'b000, 5'd8, 7'b0010011);
        mem[5]  = enc_i(12'd0, 5'd8, 3'b000, 5'd9, 7'b1100111);
        mem[6]  = enc_i(12'd3, 5'd0, 3'b000, 5'd7, 7'b0010011);
        mem[7]  = enc_i(12'd3, 5'd0, 3'b000, 5'd7, 7'b0010011);
        mem[8]  = enc_s(12'h110, 5'd9, 5'd0, 3'b010);
        mem[9]  = enc_s(12'h114, 5'd7, 5'd0, 3'b010);
        mem[10] = EBREAK;
        exp_q.push_back('{addr: 32'h110, data: 32'h0000_0018, strb: 4'b1111});
        exp_q.push_back('{addr: 32'h114, data: 32'h0000_0000, strb: 4'b1111});
        release_reset(0);
        wait_halt(200, ok);
        total++;
        if (!ok || retire_cnt != 8 || trap_cause !== 2'd0) begin
            bad++;
            $display("FAIL br_halt: halted=%b retires=%0d cause=%0d want 1/8/0",
                     halted, retire_cnt, trap_cause);
        end
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL br_store_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q[i] !== e) begin
                bad++;
                $display("FAIL br_store%0d: got %h want %h", i, obs_q[i], e);
            end
        end
    endtask

    task automatic test_trap_jump();
        int unsigned cyc;
        bit seen10;
        st_t e;
        hold_reset();
        mem[0] = enc_i(12'd7, 5'd0, 3'b000, 5'd1, 7'b0010011);
        mem[1] = enc_j(21'd6, 5'd1);
        mem[2] = EBREAK;
        mem[3] = EBREAK;
        mem[4] = enc_s(12'h110, 5'd1, 5'd0, 3'b010);
        mem[5] = EBREAK;
        exp2_q.push_back('{addr: 32'h110, data: 32'h0000_0007, strb: 4'b1111});
        release_reset(0);
        cyc = 0; seen10 = 1'b0;
        while (!(halted && halted2) && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (req2 && addr2 == 32'h10 && !seen10) begin
                seen10 = 1'b1;
                total++;
                if (cause2 !== 2'd3) begin
                    bad++;
                    $display("FAIL redirect_cause_held: cause=%0d want 3", cause2);
                end
            end
        end
        repeat (2) @(negedge clk);
        total++;
        if (halted !== 1'b1 || trap_cause !== 2'd3 || retire_cnt != 1 || obs_q.size() != 0) begin
            bad++;
            $display("FAIL jal_trap_halt: halted=%b cause=%0d retires=%0d stores=%0d want 1/3/1/0",
                     halted, trap_cause, retire_cnt, obs_q.size());
        end
        total++;
        if (!seen10 || halted2 !== 1'b1 || cause2 !== 2'd0 || retire2_cnt != 3) begin
            bad++;
            $display("FAIL jal_trap_redirect: fetched10=%b halted=%b cause=%0d retires=%0d want 1/1/0/3",
                     seen10, halted2, cause2, retire2_cnt);
        end
        total++;
        if (obs2_q.size() != exp2_q.size()) begin
            bad++;
            $display("FAIL redirect_store_count: got %0d want %0d", obs2_q.size(), exp2_q.size());
        end
        for (int i = 0; i < obs2_q.size() && exp2_q.size() > 0; i++) begin
            e = exp2_q.pop_front();
            total++;
            if (obs2_q[i] !== e) begin
                bad++;
                $display("FAIL redirect_store%0d: got %h want %h", i, obs2_q[i], e);
            end
        end
    endtask

    task automatic test_misaligned_load();
        bit ok;
        hold_reset();
        mem[0] = enc_i(12'h100, 5'd0, 3'b000, 5'd3, 7'b0010011);
        mem[1] = enc_i(12'd2, 5'd3, 3'b010, 5'd1, 7'b0000011);
        release_reset(0);
        wait_halt(200, ok);
        total++;
        if (!ok || trap_cause !== 2'd2 || retire_cnt != 1) begin
            bad++;
            $display("FAIL lw_misaligned: halted=%b cause=%0d retires=%0d want 1/2/1",
                     halted, trap_cause, retire_cnt);
        end
        total++;
        if (data_req_cnt != 0) begin
            bad++;
            $display("FAIL lw_no_req: data requests=%0d want 0", data_req_cnt);
        end
    endtask

    task automatic test_illegal();
        bit ok;
        hold_reset();
        mem[0] = 32'h0000_007F;
        release_reset(1);
        wait_halt(200, ok);
        total++;
        if (!ok || trap_cause !== 2'd1 || retire_cnt != 0) begin
            bad++;
            $display("FAIL illegal_opcode: halted=%b cause=%0d retires=%0d want 1/1/0",
                     halted, trap_cause, retire_cnt);
        end
    endtask

    task automatic test_ebreak();
        bit ok;
        int unsigned req_cycles;
        hold_reset();
        mem[0] = EBREAK;
        release_reset(0);
        wait_halt(200, ok);
        total++;
        if (!ok || trap_cause !== 2'd0 || retire_cnt != 1) begin
            bad++;
            $display("FAIL ebreak_halt: halted=%b cause=%0d retires=%0d want 1/0/1",
                     halted, trap_cause, retire_cnt);
        end
        req_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req !== 1'b0 || halted !== 1'b1 || retire !== 1'b0) req_cycles++;
        end
        total++;
        if (req_cycles != 0) begin
            bad++;
            $display("FAIL halt_absorbing: %0d of 20 cycles with req/retire or not halted, want 0",
                     req_cycles);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        wait_cfg = 0;
        test_reset();
        test_alu();
        test_store_load();
        test_wait_states();
        test_branch_jump();
        test_trap_jump();
        test_misaligned_load();
        test_illegal();
        test_ebreak();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
